// File: rtl/usb_tx_pkg.sv
// Shared USB TX definitions: buffer-tracker state encoding, write-width codes
// and the default maximum packet size.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        RESERVED = 2'd2
    } tx_state_e;

    localparam logic [1:0] WR_SIZE_B1  = 2'd0;
    localparam logic [1:0] WR_SIZE_B2  = 2'd1;
    localparam logic [1:0] WR_SIZE_B4  = 2'd2;
    localparam logic [1:0] WR_SIZE_ILL = 2'd3;

    localparam int MAX_BYTES_DEF = 64;
    localparam int SIZE_W        = 7;

    // Byte count carried by one AHB buffer write; the illegal code adds nothing.
    function automatic logic [2:0] wr_bytes(input logic [1:0] wr_size);
        case (wr_size)
            WR_SIZE_B1: wr_bytes = 3'd1;
            WR_SIZE_B2: wr_bytes = 3'd2;
            WR_SIZE_B4: wr_bytes = 3'd4;
            default:    wr_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/tx_size_tracker_if.sv
// Buffer-side and TX-side signals of the packet size tracker, grouped as one bus.
interface tx_size_tracker_if;
    import usb_tx_pkg::*;

    logic              buff_wr;
    logic [1:0]        wr_size;
    logic              tx_commit;
    logic              tx_data_req;
    logic              tx_pack_ds_clr;
    logic [SIZE_W-1:0] tx_packet_data_size;
    logic [SIZE_W-1:0] tx_remaining;
    logic              buff_resv;
    logic              tx_underrun;
    logic              size_ovf;

    modport master (
        output buff_wr, wr_size, tx_commit, tx_data_req, tx_pack_ds_clr,
        input  tx_packet_data_size, tx_remaining, buff_resv, tx_underrun, size_ovf
    );

    modport slave (
        input  buff_wr, wr_size, tx_commit, tx_data_req, tx_pack_ds_clr,
        output tx_packet_data_size, tx_remaining, buff_resv, tx_underrun, size_ovf
    );

endinterface

// File: rtl/tx_remain_counter.sv
// Bytes-remaining counter for a reserved packet: clear, load and
// single-step decrement, with a registered-count zero flag.
module tx_remain_counter
    import usb_tx_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clr,
    input  logic              load,
    input  logic [SIZE_W-1:0] load_val,
    input  logic              dec,
    output logic [SIZE_W-1:0] count,
    output logic              zero
);

    // NOTE: state uses non-blocking assignments and an async reset in the
    // sensitivity list, so all registers update together and reset needs no clock.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tx_size_tracker.sv
// USB TX packet size tracker: counts buffered bytes, reserves the buffer on
// commit and tracks consumption. Optional sticky overflow via TX_SIZE_OVF_FLAG_EN.
module tx_size_tracker
    import usb_tx_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEF
) (
    input  logic         clk,
    input  logic         n_rst,
    tx_size_tracker_if.slave bus
);

    localparam logic [7:0] MAX_SZ = 8'(MAX_BYTES);

    tx_state_e         state;
    logic [SIZE_W-1:0] size;
    logic              resv;
    logic              underrun;

    logic              clr;
    logic              wr_legal;
    logic [7:0]        sum;
    logic              sat;
    logic [SIZE_W-1:0] size_next;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic [SIZE_W-1:0] cnt_val;

    assign clr = bus.tx_pack_ds_clr;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        wr_legal  = 1'b0;
        sum       = '0;
        sat       = 1'b0;
        size_next = size;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        wr_legal = bus.buff_wr && (bus.wr_size != WR_SIZE_ILL) && (state != RESERVED);
        sum      = {1'b0, size} + {5'd0, wr_bytes(bus.wr_size)};
        sat      = wr_legal && (sum > MAX_SZ);
        if (wr_legal) begin
            size_next = sat ? MAX_SZ[SIZE_W-1:0] : sum[SIZE_W-1:0];
        end

        // Commit captures the size including any write in the same cycle.
        cnt_load = (state == FILLING) && bus.tx_commit && !clr;
        cnt_dec  = (state == RESERVED) && bus.tx_data_req && !clr;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= EMPTY;
            size     <= '0;
            resv     <= 1'b0;
            underrun <= 1'b0;
        end else if (clr) begin
            state    <= EMPTY;
            size     <= '0;
            resv     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= (state == RESERVED) && bus.tx_data_req && cnt_zero;
            case (state)
                EMPTY: begin
                    size <= size_next;
                    if (wr_legal) state <= FILLING;
                end
                FILLING: begin
                    size <= size_next;
                    if (bus.tx_commit) begin
                        resv  <= 1'b1;
                        state <= RESERVED;
                    end
                end
                RESERVED: ;
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef TX_SIZE_OVF_FLAG_EN
    logic ovf;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (sat) begin
            ovf <= 1'b1;
        end
    end

    assign bus.size_ovf = ovf;
`else
    assign bus.size_ovf = 1'b0;
`endif

    tx_remain_counter u_remain (
        .clk      (clk),
        .n_rst    (n_rst),
        .clr      (clr),
        .load     (cnt_load),
        .load_val (size_next),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    assign bus.tx_packet_data_size = size;
    assign bus.tx_remaining        = cnt_val;
    assign bus.buff_resv           = resv;
    assign bus.tx_underrun         = underrun;

endmodule
